systolic_sequencer: RTL and testbench

- Sequences one output-stationary N x N systolic matrix-multiply pass.
- On start: clears the PE accumulators, then streams k_len operand-buffer read indices.
- Generates per-row and per-column diagonally skewed operand enables, waits for the array to drain, then pulses done.
- Sits between the host command interface and the PE grid; the grid's operand and result registers are plain clocked flip-flop stages.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_sequencer_if.sv | 28 ++
 rtl/skew_line.sv | 34 +++
 rtl/systolic_sequencer.sv | 111 +++++++++++
 tb/tb_systolic_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic pass sequencer.
// Holds the FSM state type, MAC latency and drain-length helper.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } seq_state_t;

  localparam int MAC_LAT = 1;

  // Skew of the far corner PE (i+j = 2N-2) plus the MAC register.
  function automatic int drain_cycles(input int n);
    return 2 * (n - 1) + MAC_LAT;
  endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// Host command and PE-grid control bundle of the sequencer.
// master: host side (drives start/k_len); slave: sequencer side.
interface systolic_sequencer_if #(
  parameter int N  = 4,
  parameter int KW = 8
);
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          acc_clr;
  logic          feed_valid;
  logic [KW-1:0] feed_idx;
  logic [N-1:0]  row_en;
  logic [N-1:0]  col_en;
  logic          done;

  modport master (
    output start, k_len,
    input  busy, acc_clr, feed_valid, feed_idx,
    input  row_en, col_en, done
  );

  modport slave (
    input  start, k_len,
    output busy, acc_clr, feed_valid, feed_idx,
    output row_en, col_en, done
  );
endinterface

// File: rtl/skew_line.sv
// 1-bit delay chain; taps[i] is din delayed by i cycles.
// Ports: clk, rst (sync, active-high), din, taps[DEPTH].
module skew_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  logic [DEPTH-1:1] dly_q;
  logic [DEPTH-1:1] dly_d;

  always_comb begin
    dly_d    = dly_q;
    dly_d[1] = din;
    for (int i = 2; i < DEPTH; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

  // Tap 0 is the undelayed source.
  assign taps = {dly_q, din};

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one output-stationary N x N systolic matmul pass.
// Ports: clk, rst (sync, active-high), bus (slave control bundle).
module systolic_sequencer #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input logic                 clk,
  input logic                 rst,
  systolic_sequencer_if.slave bus
);
  import systolic_pkg::*;

  localparam int DW      = $clog2(2 * N);
  localparam int DRAIN_N = drain_cycles(N);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_N - 1);

  seq_state_t    state_q, state_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [KW-1:0] fcnt_q, fcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic busy;
  logic acc_clr;
  logic feed_valid;
  logic done;

  always_comb begin
    state_d    = state_q;
    klen_d     = klen_q;
    fcnt_d     = fcnt_q;
    dcnt_d     = dcnt_q;
    busy       = 1'b1;
    acc_clr    = 1'b0;
    feed_valid = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          if (bus.k_len != '0) begin
            klen_d  = bus.k_len;
            state_d = CLEAR;
          end else begin
            state_d = DONE;
          end
        end
      end
      CLEAR: begin
        acc_clr = 1'b1;
        fcnt_d  = '0;
        state_d = FEED;
      end
      FEED: begin
        feed_valid = 1'b1;
        fcnt_d     = fcnt_q + KW'(1);
        // klen_q >= 1, so the compare never wraps.
        if (fcnt_q == klen_q - KW'(1)) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      klen_q  <= '0;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.acc_clr    = acc_clr;
  assign bus.feed_valid = feed_valid;
  assign bus.feed_idx   = feed_valid ? fcnt_q : '0;
  assign bus.done       = done;

  // Same source, separate chains for row and column fanout.
  skew_line #(.DEPTH(N)) u_row_skew (
    .clk  (clk),
    .rst  (rst),
    .din  (feed_valid),
    .taps (bus.row_en)
  );

  skew_line #(.DEPTH(N)) u_col_skew (
    .clk  (clk),
    .rst  (rst),
    .din  (feed_valid),
    .taps (bus.col_en)
  );

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench for systolic_sequencer.
// Directed table, corner sequences and a random run vs a model.
module tb_systolic_sequencer;
  localparam int N  = 4;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_sequencer_if #(.N(N), .KW(KW)) bus ();
  systolic_sequencer_if #(.N(N), .KW(4))  bus4 ();

  systolic_sequencer #(.N(N), .KW(KW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  systolic_sequencer #(.N(N), .KW(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Reference model: a pass is (accept cycle t0, length k);
  // every output is a simple function of rel = cyc - t0.
  bit m_act = 0;
  int m_t0  = 0;
  int m_k   = 0;

  always @(negedge clk) begin
    int rel, last, s;
    bit e_busy, e_clr, e_fv, e_done;
    int e_idx;
    logic [N-1:0] e_en;
    e_busy = 0; e_clr = 0; e_fv = 0; e_done = 0;
    e_idx = 0; e_en = '0;
    rel = cyc - m_t0;
    if (m_act) begin
      last   = (m_k == 0) ? 1 : m_k + 2 * N + 1;
      e_busy = (rel >= 1) && (rel <= last);
      e_done = (rel == last);
      if (m_k != 0) begin
        e_clr = (rel == 1);
        e_fv  = (rel >= 2) && (rel <= m_k + 1);
        e_idx = e_fv ? rel - 2 : 0;
        for (int i = 0; i < N; i++) begin
          s = rel - i;
          e_en[i] = (s >= 2) && (s <= m_k + 1);
        end
      end
    end
    if (chk_en) begin
      checks++;
      if (bus.busy !== e_busy || bus.acc_clr !== e_clr ||
          bus.feed_valid !== e_fv ||
          bus.feed_idx !== KW'(e_idx) ||
          bus.row_en !== e_en || bus.col_en !== e_en ||
          bus.done !== e_done) begin
        errors++;
        $display("FAIL model cyc=%0d got b%b c%b v%b i%0d r%b k%b d%b want b%b c%b v%b i%0d r%b k%b d%b",
          cyc, bus.busy, bus.acc_clr, bus.feed_valid, bus.feed_idx,
          bus.row_en, bus.col_en, bus.done,
          e_busy, e_clr, e_fv, e_idx, e_en, e_en, e_done);
      end
    end
    if (rst) begin
      m_act = 0;
    end else if (bus.start && !e_busy) begin
      m_act = 1;
      m_t0  = cyc;
      m_k   = int'(bus.k_len);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input logic [KW-1:0] k, input int budget,
                          output int lat, output int feeds,
                          output int clrs, output int busyc,
                          output int r3c, output int idx_ok);
    int t0;
    lat = -1; feeds = 0; clrs = 0; busyc = 0; r3c = 0; idx_ok = 1;
    bus.start = 1'b1;
    bus.k_len = k;
    t0 = cyc;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.acc_clr) clrs++;
      if (bus.busy) busyc++;
      if (bus.row_en[N-1]) r3c++;
      if (bus.feed_valid) begin
        if (int'(bus.feed_idx) != feeds) idx_ok = 0;
        feeds++;
      end
      if (bus.done) begin
        lat = cyc - t0;
        break;
      end
      tick();
      bus.start = 1'b0;
    end
    bus.start = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [KW-1:0] k;
    int lat;
    int feeds;
    int clrs;
    int busyc;
    int r3c;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat, feeds, clrs, busyc, r3c, idx_ok;
    int t0, nd, dc0, dc1, ones;
    bus.start  = 1'b0;
    bus.k_len  = '0;
    bus4.start = 1'b0;
    bus4.k_len = '0;

    tbl[0] = '{8'd3,   12,  3,   1, 12,  3};
    tbl[1] = '{8'd0,   1,   0,   0, 1,   0};
    tbl[2] = '{8'd1,   10,  1,   1, 10,  1};
    tbl[3] = '{8'd7,   16,  7,   1, 16,  7};
    tbl[4] = '{8'd255, 264, 255, 1, 264, 255};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_outs", int'({bus.acc_clr, bus.feed_valid,
        bus.done, bus.row_en, bus.col_en}), 0);
    tick();

    foreach (tbl[i]) begin
      run_pass(tbl[i].k, tbl[i].lat + 10,
               lat, feeds, clrs, busyc, r3c, idx_ok);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_feeds", i), feeds, tbl[i].feeds);
      chk($sformatf("tbl%0d_clrs", i), clrs, tbl[i].clrs);
      chk($sformatf("tbl%0d_busy", i), busyc, tbl[i].busyc);
      chk($sformatf("tbl%0d_row3", i), r3c, tbl[i].r3c);
      chk($sformatf("tbl%0d_idx", i), idx_ok, 1);
    end

    // Back-to-back: start held with k_len=1.
    bus.start = 1'b1;
    bus.k_len = 8'd1;
    t0 = cyc;
    nd = 0; dc0 = -1; dc1 = -1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (bus.done) begin
        if (nd == 0) dc0 = cyc - t0;
        if (nd == 1) dc1 = cyc - t0;
        nd++;
      end
      tick();
    end
    bus.start = 1'b0;
    chk("b2b_count", nd, 2);
    chk("b2b_done0", dc0, 10);
    chk("b2b_done1", dc1, 21);
    repeat (15) tick();

    // Start pulses while busy (CLEAR..DONE) are ignored.
    bus.start = 1'b1;
    bus.k_len = 8'd2;
    t0 = cyc;
    tick();
    bus.k_len = 8'd0;
    nd = 0; dc0 = -1;
    for (int n = 1; n < 25; n++) begin
      if (n == 12) bus.start = 1'b0;
      @(negedge clk);
      if (bus.done) begin
        if (nd == 0) dc0 = cyc - t0;
        nd++;
      end
      tick();
    end
    bus.start = 1'b0;
    chk("busy_start_count", nd, 1);
    chk("busy_start_lat", dc0, 11);

    // Reset during the second FEED cycle of a k_len=5 pass.
    bus.start = 1'b1;
    bus.k_len = 8'd5;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_feed", int'(bus.feed_valid), 0);
    chk("rst_mid_idx", int'(bus.feed_idx), 0);
    chk("rst_mid_taps", int'({bus.row_en, bus.col_en}), 0);
    nd = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.done) nd++;
      tick();
    end
    chk("rst_mid_nodone", nd, 0);
    run_pass(8'd2, 20, lat, feeds, clrs, busyc, r3c, idx_ok);
    chk("rst_fresh_lat", lat, 11);
    chk("rst_fresh_feeds", feeds, 2);

    // Max length on the KW=4 instance.
    bus4.start = 1'b1;
    bus4.k_len = 4'd15;
    t0 = cyc;
    feeds = 0; idx_ok = 1; lat = -1; ones = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus4.feed_valid) begin
        if (int'(bus4.feed_idx) != feeds) idx_ok = 0;
        ones = int'(bus4.feed_idx);
        feeds++;
      end
      if (bus4.done) begin
        lat = cyc - t0;
        break;
      end
      tick();
      bus4.start = 1'b0;
    end
    bus4.start = 1'b0;
    tick();
    chk("max_lat", lat, 24);
    chk("max_feeds", feeds, 15);
    chk("max_idx_seq", idx_ok, 1);
    chk("max_last_idx", ones, 14);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0)
        bus.k_len = KW'($urandom_range(0, 255));
      else
        bus.k_len = KW'($urandom_range(0, 5));
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (300) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
